// File: rtl/np_mc_core.sv
// np_mc_core: multi-cycle NP processor core with req/ack instruction and data ports
// Ports: clk, reset (async, active-low); imem_req/imem_addr/imem_rdata/imem_ack fetch port;
// dmem_req/dmem_wr/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack data port;
// halt, illegal, retire status; psr = {NEG,ZERO,PARITY,EVEN,CARRY}.
// Define NP_MUL_EN to build the multiplier; without it opcode 5 traps as illegal.
module np_mc_core #(
  parameter int WIDTH = 32,
  parameter int ADDRSIZE = 12,
  parameter int REGBITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDRSIZE-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_wr,
  output logic [ADDRSIZE-1:0] dmem_addr,
  output logic [WIDTH-1:0]    dmem_wdata,
  input  logic [WIDTH-1:0]    dmem_rdata,
  input  logic                dmem_ack,
  output logic                halt,
  output logic                illegal,
  output logic                retire,
  output logic [4:0]          psr
);
  typedef enum logic [2:0] {FET, EXE, MEM, WB, HALT} state_t;
  state_t state, next;
  logic [31:0] ir;
  logic [ADDRSIZE-1:0] pc, npc;
  logic [WIDTH:0] res, alu;
  logic [WIDTH-1:0] rf [2**REGBITS];
  logic [WIDTH-1:0] s, a, shf, rot, val, mul;
  logic [15:0] conds;
  logic [3:0] op;
  logic alu_op, bad, memop, hret, taken;
  logic signed [11:0] cnt;
  int mag, rr;
  assign op = ir[31:28];
  assign alu_op = op >= 4'd3 && op <= 4'd10;
`ifdef NP_MUL_EN
  assign bad = op >= 4'd12 || (alu_op && ir[26]);
  assign mul = a * s;
`else
  assign bad = op >= 4'd12 || (alu_op && ir[26]) || op == 4'd5;
  assign mul = '0;
`endif
  assign memop = op == 4'd2 || (op == 4'd3 && !ir[27]);
  assign s = ir[27] ? WIDTH'(ir[23:12]) : rf[ir[12+:REGBITS]];
  assign a = rf[ir[0+:REGBITS]];
  // condition table indexed by ccode: 0 always, 1..5 psr bits, 6..15 never
  assign conds = {10'b0, psr, 1'b1};
  assign taken = op == 4'd1 && conds[ir[27:24]];
  // shift/rotate count is the signed low 12 bits of the source operand
  assign cnt = s[11:0];
  always_comb begin
    mag = cnt[11] ? -int'(cnt) : int'(cnt);
    rr = cnt[11] ? (WIDTH - mag % WIDTH) % WIDTH : mag % WIDTH;
  end
  assign shf = cnt[11] ? a << mag : a >> mag;
  // left rotation is folded into an equivalent right rotation by rr
  assign rot = (a >> rr) | (a << (WIDTH - rr));
  assign val = op == 4'd3 ? s : op == 4'd5 ? mul : op == 4'd6 ? ~s :
               op == 4'd7 ? shf : op == 4'd8 ? rot : a | s;
  assign alu = op == 4'd4 ? {1'b0, a} + {1'b0, s} :
               op == 4'd9 ? {1'b0, a} - {1'b0, s} : {1'b0, val};
  assign imem_req = reset && state == FET;
  assign imem_addr = pc;
  assign dmem_req = state == MEM;
  assign halt = state == HALT;
  assign retire = state == WB || hret;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FET;
    else state <= next;
  always_comb begin
    next = state;
    if (state == FET && imem_ack) next = EXE;
    if (state == EXE) next = (bad || op == 4'd11) ? HALT : memop ? MEM : WB;
    if (state == MEM && dmem_ack) next = WB;
    if (state == WB) next = FET;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ir <= '0;
      pc <= '0;
      npc <= '0;
      res <= '0;
      psr <= '0;
      illegal <= 1'b0;
      hret <= 1'b0;
      dmem_wr <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 2**REGBITS; i++) rf[i] <= '0;
    end else begin
      // HLT retires in its first halted cycle instead of passing through WB
      hret <= state == EXE && op == 4'd11;
      if (state == FET && imem_ack) ir <= imem_rdata;
      if (state == EXE) begin
        res <= alu;
        npc <= taken ? ADDRSIZE'(ir[11:0]) : pc + 1'b1;
        illegal <= bad;
        dmem_wr <= op == 4'd2;
        dmem_addr <= ADDRSIZE'(op == 4'd2 ? ir[11:0] : ir[23:12]);
        dmem_wdata <= s;
      end
      if (state == MEM && dmem_ack && !dmem_wr) res <= {1'b0, dmem_rdata};
      if (state == WB) begin
        pc <= npc;
        if (alu_op) begin
          rf[ir[0+:REGBITS]] <= res[WIDTH-1:0];
          psr <= {res[WIDTH-1], res[WIDTH-1:0] == '0, ^res[WIDTH-1:0], ~res[0], res[WIDTH]};
        end
      end
    end
endmodule

// File: tb/tb_np_mc_core.sv
// tb_np_mc_core: scoreboard bench for np_mc_core with an instruction-level ISA model
module tb_np_mc_core;
  logic clk = 0, reset = 0;
  logic imem_req, imem_ack = 0, dmem_req, dmem_wr, dmem_ack = 0, halt, illegal, retire;
  logic [11:0] imem_addr, dmem_addr;
  logic [31:0] imem_rdata = 0, dmem_wdata, dmem_rdata = 0;
  logic [4:0] psr;
  int errors = 0, checks = 0;
`ifdef NP_MUL_EN
  localparam bit MUL = 1;
`else
  localparam bit MUL = 0;
`endif
  typedef struct {logic wr; logic [11:0] addr; logic [31:0] wdata;} dacc_t;
  typedef struct {logic [4:0] psr; int lat;} ret_t;
  logic [31:0] prog [4096];
  logic [31:0] mem [4096];
  logic [31:0] mem_m [4096];
  int fq[$], fwq[$], dwq[$];
  dacc_t dq[$];
  ret_t rq[$];
  logic exp_ill;
  int fwmin, fwmax, dwmin, dwmax;

  np_mc_core dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halt(halt), .illegal(illegal), .retire(retire), .psr(psr)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] enc(input int op, input int cc, input int src, input int dst);
    return {4'(op), 4'(cc), 12'(src), 12'(dst)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = 32'hB000_0000;
  endtask

  // Executes the program one instruction at a time and queues every observable effect.
  task automatic run_model();
    logic [31:0] r_m [16];
    logic [4:0] p;
    int pc, fw, dw, lat, npc, c, m;
    logic [31:0] w, sv, a, v;
    logic [3:0] op, cc;
    logic [32:0] r;
    logic [63:0] t;
    bit tk;
    for (int i = 0; i < 16; i++) r_m[i] = 0;
    p = 0;
    pc = 0;
    exp_ill = 0;
    for (int step = 0; step < 400; step++) begin
      w = prog[pc];
      op = w[31:28];
      cc = w[27:24];
      fw = $urandom_range(fwmax, fwmin);
      fq.push_back(pc);
      fwq.push_back(fw);
      sv = w[27] ? {20'b0, w[23:12]} : r_m[w[15:12]];
      a = r_m[w[3:0]];
      if (op >= 12 || (op >= 3 && op <= 10 && w[26]) || (op == 5 && !MUL)) begin
        exp_ill = 1;
        return;
      end
      lat = 3 + fw;
      npc = (pc + 1) % 4096;
      if (op == 11) begin
        rq.push_back('{p, lat});
        return;
      end
      if (op == 1) begin
        tk = cc == 0 || (cc == 1 && p[0]) || (cc == 2 && p[1]) || (cc == 3 && p[2]) ||
             (cc == 4 && p[3]) || (cc == 5 && p[4]);
        if (tk) npc = w[11:0];
      end
      if (op == 2) begin
        dw = $urandom_range(dwmax, dwmin);
        dq.push_back('{1'b1, w[11:0], sv});
        dwq.push_back(dw);
        mem_m[w[11:0]] = sv;
        lat += 1 + dw;
      end
      if (op >= 3 && op <= 10) begin
        c = int'($signed(sv[11:0]));
        m = c < 0 ? -c : c;
        v = 0;
        t = 64'(a) + 64'(sv);
        case (op)
          3: if (w[27]) v = sv;
             else begin
               dw = $urandom_range(dwmax, dwmin);
               dq.push_back('{1'b0, w[23:12], 32'h0});
               dwq.push_back(dw);
               v = mem_m[w[23:12]];
               lat += 1 + dw;
             end
          5: v = a * sv;
          6: v = ~sv;
          7: v = m >= 32 ? 32'h0 : c > 0 ? a >> m : a << m;
          8: begin
               v = a;
               repeat (m % 32) v = c > 0 ? {v[0], v[31:1]} : {v[30:0], v[31]};
             end
          10: v = a | sv;
          default: v = 0;
        endcase
        r = op == 4 ? t[32:0] : op == 9 ? {a < sv, a - sv} : {1'b0, v};
        r_m[w[3:0]] = r[31:0];
        p = {r[31], r[31:0] == 0, ^r[31:0], ~r[0], r[32]};
      end
      rq.push_back('{p, lat});
      pc = npc;
    end
  endtask

  // instruction memory responder
  initial begin
    bit ibusy;
    int iw, e;
    logic [11:0] ia;
    ibusy = 0;
    iw = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ibusy = 0;
        imem_ack = 0;
      end else if (imem_req) begin
        if (!ibusy) begin
          ibusy = 1;
          ia = imem_addr;
          if (fq.size() == 0) begin
            fail("fetch_unexpected");
            iw = 0;
          end else begin
            e = fq.pop_front();
            iw = fwq.pop_front();
            chk("fetch_addr", imem_addr, e);
          end
        end else chk("fetch_hold", imem_addr, ia);
        if (iw == 0) begin
          imem_ack = 1;
          imem_rdata = prog[imem_addr];
          ibusy = 0;
        end else begin
          iw--;
          imem_ack = 0;
        end
      end else imem_ack = 0;
    end
  end

  // data memory responder
  initial begin
    bit dbusy;
    int dwt;
    logic dwr;
    logic [11:0] dad;
    logic [31:0] dwd;
    dacc_t de;
    dbusy = 0;
    dwt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dbusy = 0;
        dmem_ack = 0;
      end else if (dmem_req) begin
        if (!dbusy) begin
          dbusy = 1;
          dwr = dmem_wr;
          dad = dmem_addr;
          dwd = dmem_wdata;
          if (dq.size() == 0) begin
            fail("dmem_unexpected");
            dwt = 0;
          end else begin
            de = dq.pop_front();
            dwt = dwq.pop_front();
            chk("dmem_wr", dmem_wr, de.wr);
            chk("dmem_addr", dmem_addr, de.addr);
            if (de.wr) chk("dmem_wdata", dmem_wdata, de.wdata);
          end
        end else chk("dmem_hold", {dmem_wr, dmem_addr, dmem_wdata}, {dwr, dad, dwd});
        if (dwt == 0) begin
          dmem_ack = 1;
          if (dmem_wr) mem[dmem_addr] = dmem_wdata;
          else dmem_rdata = mem[dmem_addr];
          dbusy = 0;
        end else begin
          dwt--;
          dmem_ack = 0;
        end
      end else dmem_ack = 0;
    end
  end

  // retire monitor: latency per instruction and psr in the cycle after write-back
  initial begin
    int cyc, last;
    bit pend;
    logic [4:0] pend_psr;
    ret_t re;
    cyc = 0;
    last = -1;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0;
        cyc = 0;
        last = -1;
      end else begin
        if (imem_req && dmem_req) fail("req_overlap");
        if (pend) begin
          chk("psr", psr, pend_psr);
          pend = 0;
        end
        if (retire) begin
          if (rq.size() == 0) fail("retire_unexpected");
          else begin
            re = rq.pop_front();
            chk("retire_latency", cyc - last, re.lat);
            last = cyc;
            pend = 1;
            pend_psr = re.psr;
          end
        end
        cyc++;
      end
    end
  end

  task automatic run_prog(input int fmin, input int fmax, input int dmin, input int dmax);
    reset = 0;
    fq.delete();
    fwq.delete();
    dq.delete();
    dwq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", {imem_req, dmem_req, dmem_wr, halt, illegal, retire, psr, imem_addr, dmem_addr},
           0);
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      mem_m[i] = mem[i];
    end
    fwmin = fmin;
    fwmax = fmax;
    dwmin = dmin;
    dwmax = dmax;
    run_model();
    @(posedge clk);
    #2 reset = 1;
    for (int i = 0; i < 3000 && !halt; i++) @(negedge clk);
    if (!halt) fail("halt_timeout");
    repeat (6) @(negedge clk);
    chk("halt", halt, 1);
    chk("illegal", illegal, exp_ill);
    chk("queues_drained", fq.size() + rq.size() + dq.size(), 0);
  endtask

  task automatic gen_random();
    int r, op, st, sr, dr, x;
    clear_prog();
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      sr = $urandom_range(0, 3) + 16 * $urandom_range(0, 255);
      dr = $urandom_range(0, 3) + 16 * $urandom_range(0, 255);
      st = $urandom_range(0, 1);
      x = $urandom_range(0, 4095);
      if (r <= 5) begin
        op = $urandom_range(3, 10);
        if (op == 5 && !MUL) op = 4;
        if (op == 7 || op == 8) x = $urandom_range(0, 80) - 40;
        if (op == 3 && st == 0) prog[k] = enc(3, 0, 'h100 + $urandom_range(0, 15), dr);
        else prog[k] = enc(op, st ? 8 : 0, st ? x : sr, dr);
      end else if (r <= 7) prog[k] = enc(2, st ? 8 : 0, st ? x : sr, 'h100 + $urandom_range(0, 15));
      else if (r == 8) prog[k] = enc(1, $urandom_range(0, 7), 0, k + $urandom_range(1, 3));
      else prog[k] = enc(0, $urandom_range(0, 15), x, x);
    end
  endtask

  initial begin
    #1 chk("reset_initial", {imem_req, dmem_req, halt, illegal, retire, psr, imem_addr}, 0);
    // abort a stalled fetch with an asynchronous reset
    clear_prog();
    fq.push_back(0);
    fwq.push_back(5);
    @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    #1 chk("fetch_req_up", imem_req, 1);
    @(negedge clk);
    #2 reset = 0;
    #1 chk("reset_midfetch", {imem_req, halt, psr, imem_addr}, 0);
    // LD R1,#5; LD R2,#3; SUB R1,R2; STR R1->0x020; HLT
    clear_prog();
    prog[0] = enc(3, 8, 5, 1);
    prog[1] = enc(3, 8, 3, 2);
    prog[2] = enc(9, 0, 2, 1);
    prog[3] = enc(2, 0, 1, 'h20);
    run_prog(0, 0, 0, 0);
    // taken and not-taken branches; the wrong path hits an illegal opcode
    clear_prog();
    prog[0] = enc(3, 8, 0, 0);
    prog[1] = enc(1, 4, 0, 'h10);
    prog[2] = enc(12, 0, 0, 0);
    run_prog(0, 0, 0, 0);
    clear_prog();
    prog[0] = enc(3, 8, 0, 0);
    prog[1] = enc(1, 6, 0, 'h10);
    prog[16] = enc(12, 0, 0, 0);
    run_prog(0, 0, 0, 0);
    // store immediate with two data wait cycles
    clear_prog();
    prog[0] = enc(2, 8, 'hABC, 'h20);
    run_prog(0, 0, 2, 2);
    // rotate and shift corner cases
    clear_prog();
    prog[0] = enc(3, 8, 1, 3);
    prog[1] = enc(3, 8, 1, 4);
    prog[2] = enc(8, 8, 1, 4);
    prog[3] = enc(10, 0, 4, 3);
    prog[4] = enc(8, 8, 1, 3);
    prog[5] = enc(2, 0, 3, 'h30);
    prog[6] = enc(8, 8, 'hFFF, 3);
    prog[7] = enc(8, 8, 'hFFF, 3);
    prog[8] = enc(2, 0, 3, 'h31);
    prog[9] = enc(7, 8, 40, 3);
    prog[10] = enc(2, 0, 3, 'h32);
    run_prog(0, 0, 0, 0);
    // illegal opcode, MUL, and dsttype on an ALU op
    clear_prog();
    prog[0] = enc(3, 8, 7, 1);
    prog[1] = enc(12, 0, 0, 0);
    run_prog(0, 1, 0, 1);
    clear_prog();
    prog[0] = enc(3, 8, 6, 1);
    prog[1] = enc(3, 8, 7, 2);
    prog[2] = enc(5, 0, 2, 1);
    prog[3] = enc(2, 0, 1, 'h40);
    run_prog(0, 0, 0, 0);
    clear_prog();
    prog[0] = enc(4, 4, 1, 1);
    run_prog(0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      gen_random();
      run_prog(0, 2, 0, 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
